// File: rtl/tpu_matmul_sequencer_pkg.sv
// Shared definitions for the matmul tile sequencer: FSM encoding and datapath sizing.
package tpu_matmul_sequencer_pkg;

    localparam int MATRIX_SIZE            = 8;
    localparam int DEFAULT_RESULT_LATENCY = 2 * MATRIX_SIZE;
    localparam int PARTIAL_SUM_BW         = 32;
    // Result SRAM row width, used by the top level when sizing the result memory.
    localparam int RESULT_ROW_W           = PARTIAL_SUM_BW * MATRIX_SIZE;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WFETCH = 3'd1,
        ST_WLOAD  = 3'd2,
        ST_STREAM = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/tpu_matmul_sequencer_if.sv
// Control/config and memory-sequencing signals between the host side and the sequencer.
interface tpu_matmul_sequencer_if #(
    parameter int ADDRESSSIZE      = 10,
    parameter int ADDRESSSIZE_fifo = 2
);
    logic                        start;
    logic                        abort;
    logic [ADDRESSSIZE-1:0]      cfg_src_base;
    logic [ADDRESSSIZE-1:0]      cfg_dst_base;
    logic [ADDRESSSIZE:0]        cfg_num_rows;
    logic [ADDRESSSIZE_fifo-1:0] cfg_weight_slot;
    logic [ADDRESSSIZE_fifo-1:0] weight_address;
    logic                        we_rl;
    logic [ADDRESSSIZE-1:0]      ub_address;
    logic                        ub_issue;
    logic                        res_write_enable;
    logic [ADDRESSSIZE-1:0]      res_address;
    logic                        busy;
    logic                        done;

    modport master (
        output start, abort, cfg_src_base, cfg_dst_base, cfg_num_rows, cfg_weight_slot,
        input  weight_address, we_rl, ub_address, ub_issue, res_write_enable,
               res_address, busy, done
    );

    modport slave (
        input  start, abort, cfg_src_base, cfg_dst_base, cfg_num_rows, cfg_weight_slot,
        output weight_address, we_rl, ub_address, ub_issue, res_write_enable,
               res_address, busy, done
    );
endinterface

// File: rtl/tpu_matmul_sequencer_valid_delay.sv
// Fixed-depth 1-bit delay line turning UB issue strobes into result write strobes.
module tpu_matmul_sequencer_valid_delay #(
    parameter int DEPTH = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic din,
    output logic dout
);
    logic [DEPTH-1:0] stage_reg;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or posedge rst) begin
                    if (rst)        stage_reg[gi] <= 1'b0;
                    else if (flush) stage_reg[gi] <= 1'b0;
                    else            stage_reg[gi] <= din;
                end
            end else begin : g_tail
                always_ff @(posedge clk or posedge rst) begin
                    if (rst)        stage_reg[gi] <= 1'b0;
                    else if (flush) stage_reg[gi] <= 1'b0;
                    else            stage_reg[gi] <= stage_reg[gi-1];
                end
            end
        end
    endgenerate

    assign dout = stage_reg[DEPTH-1];
endmodule

// File: rtl/tpu_matmul_sequencer.sv
// One-tile matmul sequencer: weight fetch/reload, activation row streaming, delayed result writes.
module tpu_matmul_sequencer
    import tpu_matmul_sequencer_pkg::*;
#(
    parameter int ADDRESSSIZE      = 10,
    parameter int ADDRESSSIZE_fifo = 2,
    parameter int RESULT_LATENCY   = DEFAULT_RESULT_LATENCY
) (
    input logic                    clk,
    input logic                    rst,
    tpu_matmul_sequencer_if.slave  bus
);
    state_t                      state_reg;
    logic [ADDRESSSIZE-1:0]      src_reg;
    logic [ADDRESSSIZE-1:0]      dst_reg;
    logic [ADDRESSSIZE:0]        num_reg;
    logic [ADDRESSSIZE:0]        row_cnt_reg;
    logic [ADDRESSSIZE:0]        wr_cnt_reg;
    logic [ADDRESSSIZE_fifo-1:0] weight_address_reg;
    logic                        we_rl_reg;
    logic [ADDRESSSIZE-1:0]      ub_address_reg;
    logic                        ub_issue_reg;
    logic                        busy_reg;
    logic                        done_reg;
    logic                        res_we;
    logic                        flush;

    assign flush = bus.abort && (state_reg != ST_IDLE);

    tpu_matmul_sequencer_valid_delay #(.DEPTH(RESULT_LATENCY)) u_valid_delay (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .din   (ub_issue_reg),
        .dout  (res_we)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg          <= ST_IDLE;
            src_reg            <= '0;
            dst_reg            <= '0;
            num_reg            <= '0;
            row_cnt_reg        <= '0;
            wr_cnt_reg         <= '0;
            weight_address_reg <= '0;
            we_rl_reg          <= 1'b0;
            ub_address_reg     <= '0;
            ub_issue_reg       <= 1'b0;
            busy_reg           <= 1'b0;
            done_reg           <= 1'b0;
        end else if (flush) begin
            state_reg          <= ST_IDLE;
            weight_address_reg <= '0;
            we_rl_reg          <= 1'b0;
            ub_address_reg     <= '0;
            ub_issue_reg       <= 1'b0;
            busy_reg           <= 1'b0;
            done_reg           <= 1'b0;
        end else begin
            if (res_we) wr_cnt_reg <= wr_cnt_reg + 1'b1;
            case (state_reg)
                ST_IDLE: begin
                    done_reg <= 1'b0;
                    // abort in IDLE suppresses a simultaneous start
                    if (bus.start && !bus.abort) begin
                        src_reg    <= bus.cfg_src_base;
                        dst_reg    <= bus.cfg_dst_base;
                        num_reg    <= bus.cfg_num_rows;
                        wr_cnt_reg <= '0;
                        busy_reg   <= 1'b1;
                        if (bus.cfg_num_rows == '0) begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg          <= ST_WFETCH;
                            weight_address_reg <= bus.cfg_weight_slot;
                        end
                    end
                end
                ST_WFETCH: begin
                    we_rl_reg <= 1'b1;
                    state_reg <= ST_WLOAD;
                end
                ST_WLOAD: begin
                    we_rl_reg          <= 1'b0;
                    weight_address_reg <= '0;
                    ub_issue_reg       <= 1'b1;
                    ub_address_reg     <= src_reg;
                    row_cnt_reg        <= '0;
                    state_reg          <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (row_cnt_reg == num_reg - 1'b1) begin
                        ub_issue_reg   <= 1'b0;
                        ub_address_reg <= '0;
                        state_reg      <= ST_DRAIN;
                    end else begin
                        row_cnt_reg    <= row_cnt_reg + 1'b1;
                        ub_address_reg <= ub_address_reg + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (res_we && (wr_cnt_reg == num_reg - 1'b1)) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.weight_address   = weight_address_reg;
    assign bus.we_rl            = we_rl_reg;
    assign bus.ub_address       = ub_address_reg;
    assign bus.ub_issue         = ub_issue_reg;
    assign bus.res_write_enable = res_we;
    assign bus.res_address      = res_we ? (dst_reg + wr_cnt_reg[ADDRESSSIZE-1:0]) : '0;
    assign bus.busy             = busy_reg;
    assign bus.done             = done_reg;
endmodule

// File: tb/tb_tpu_matmul_sequencer.sv
// Bench for tpu_matmul_sequencer: cycle-accurate comparison against a job-timeline model.
module tb_tpu_matmul_sequencer;
    localparam int A = 10;
    localparam int F = 2;
    localparam int L = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    tpu_matmul_sequencer_if #(.ADDRESSSIZE(A), .ADDRESSSIZE_fifo(F)) bus ();

    tpu_matmul_sequencer #(.ADDRESSSIZE(A), .ADDRESSSIZE_fifo(F), .RESULT_LATENCY(L)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string      tag;
        logic [9:0] src;
        logic [9:0] dst;
        int         n;
        logic [1:0] slot;
        int         ac;        // abort cycle, 0 = none
        bit         spam;      // hammer start and change cfg while running
        int         exp_done;  // expected done cycle, -1 = none
        logic [9:0] exp_last;  // expected last result address (0 if no writes)
    } vec_t;

    // {busy, done, we_rl, ub_issue, res_we, weight_address, ub_address, res_address}
    function automatic logic [26:0] sample();
        return {bus.busy, bus.done, bus.we_rl, bus.ub_issue, bus.res_write_enable,
                bus.weight_address, bus.ub_address, bus.res_address};
    endfunction

    // Expected outputs in cycle c of a job whose start was accepted at the end of cycle 0.
    function automatic logic [26:0] model(input logic [9:0] src, input logic [9:0] dst,
                                          input int n, input logic [1:0] slot,
                                          input int ac, input int c);
        bit busy = 0, dn = 0, we = 0, iss = 0, rwe = 0;
        logic [1:0] wa = '0;
        logic [9:0] ua = '0, ra = '0;
        if (ac != 0 && c > ac) return '0;
        if (n == 0) begin
            busy = (c == 1);
            dn   = (c == 1);
        end else begin
            busy = (c >= 1) && (c <= n + 3 + L);
            dn   = (c == n + 3 + L);
            wa   = (c == 1 || c == 2) ? slot : 2'd0;
            we   = (c == 2);
            iss  = (c >= 3) && (c <= n + 2);
            if (iss) ua = src + 10'(c - 3);
            rwe  = (c - L >= 3) && (c - L <= n + 2);
            if (rwe) ra = dst + 10'(c - L - 3);
        end
        return {busy, dn, we, iss, rwe, wa, ua, ra};
    endfunction

    task automatic check(input string name, input logic [26:0] act, input logic [26:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Entered and left #1 after a rising edge with the DUT idle.
    task automatic run_job(input vec_t v, output int done_cyc, output logic [9:0] last_res);
        int total    = v.n + L + 6;
        int end_cyc  = (v.n == 0) ? 1 : v.n + 3 + L;
        int start_to = (v.ac != 0 && v.ac < end_cyc) ? v.ac : end_cyc;
        done_cyc = -1;
        last_res = '0;
        bus.cfg_src_base    = v.src;
        bus.cfg_dst_base    = v.dst;
        bus.cfg_num_rows    = 11'(v.n);
        bus.cfg_weight_slot = v.slot;
        bus.start           = 1'b1;
        bus.abort           = 1'b0;
        for (int c = 0; c <= total; c++) begin
            @(negedge clk);
            check($sformatf("%s cyc%0d", v.tag, c), sample(),
                  model(v.src, v.dst, v.n, v.slot, v.ac, c));
            if (bus.done && done_cyc < 0) done_cyc = c;
            if (bus.res_write_enable) last_res = bus.res_address;
            @(posedge clk);
            #1;
            bus.start = v.spam && (c + 1 <= start_to);
            bus.abort = (v.ac != 0) && (c + 1 == v.ac);
            if (v.spam) begin
                bus.cfg_num_rows    = 11'($urandom_range(0, 2047));
                bus.cfg_src_base    = 10'($urandom);
                bus.cfg_dst_base    = 10'($urandom);
                bus.cfg_weight_slot = 2'($urandom);
            end
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        $display("job %s src=%h dst=%h n=%0d slot=%0d abort=%0d spam=%0d done_cyc=%0d",
                 v.tag, v.src, v.dst, v.n, v.slot, v.ac, v.spam, done_cyc);
    endtask

    vec_t vecs[7];
    vec_t rv;
    int   dc;
    logic [9:0] lr;

    initial begin
        vecs[0] = '{"basic",   10'h010, 10'h200, 8,    2'd2, 0,  1'b0, 27,   10'h207};
        vecs[1] = '{"wrap",    10'h3FE, 10'h3FF, 4,    2'd1, 0,  1'b0, 23,   10'h002};
        vecs[2] = '{"zero",    10'h055, 10'h066, 0,    2'd3, 0,  1'b0, 1,    10'h000};
        vecs[3] = '{"spam",    10'h020, 10'h050, 5,    2'd1, 0,  1'b1, 24,   10'h054};
        vecs[4] = '{"abort12", 10'h010, 10'h200, 8,    2'd2, 12, 1'b0, -1,   10'h000};
        vecs[5] = '{"rerun",   10'h010, 10'h200, 8,    2'd2, 0,  1'b0, 27,   10'h207};
        vecs[6] = '{"full",    10'h000, 10'h100, 1024, 2'd0, 0,  1'b0, 1043, 10'h0FF};

        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.cfg_src_base = '0;
        bus.cfg_dst_base = '0;
        bus.cfg_num_rows = '0;
        bus.cfg_weight_slot = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", sample(), '0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            run_job(vecs[i], dc, lr);
            check_int({vecs[i].tag, " done_cycle"}, dc, vecs[i].exp_done);
            check_int({vecs[i].tag, " last_res"}, int'(lr), int'(vecs[i].exp_last));
        end

        // Reset asserted mid-STREAM clears outputs immediately, then sequencer sits idle.
        bus.cfg_src_base = 10'h010; bus.cfg_dst_base = 10'h200;
        bus.cfg_num_rows = 11'd8;   bus.cfg_weight_slot = 2'd2;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        check("pre_reset_stream", sample(), model(10'h010, 10'h200, 8, 2'd2, 0, 6));
        rst = 1'b1;
        #1;
        check("reset_same_cycle", sample(), '0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("post_reset idle%0d", c), sample(), '0);
            @(posedge clk); #1;
        end

        // abort beats start in IDLE.
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check($sformatf("abort_over_start cyc%0d", c), sample(), '0);
            @(posedge clk); #1;
        end
        $display("job abort_over_start ignored");

        // Randomized jobs against the timeline model.
        for (int i = 0; i < 10; i++) begin
            rv.tag  = $sformatf("rand%0d", i);
            rv.src  = 10'($urandom);
            rv.dst  = 10'($urandom);
            rv.n    = $urandom_range(0, 40);
            rv.slot = 2'($urandom);
            rv.ac   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, rv.n + 2 + L) : 0;
            rv.spam = 1'($urandom_range(0, 1));
            rv.exp_done = -1;
            rv.exp_last = '0;
            run_job(rv, dc, lr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
